// File: rtl/fp_div_seq_if.sv
// Handshake/bus bundle for the sequential single-precision divider.
interface fp_div_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] y;
  logic        dbz;

  modport master (output start, a, b, input busy, done, y, dbz);
  modport slave  (input start, a, b, output busy, done, y, dbz);
endinterface

// File: rtl/fp_div_seq.sv
// IEEE-754 single-precision divider, 1 quotient bit per cycle (restoring),
// fixed 26-cycle latency for every operand class, truncating rounding.
module fp_div_seq #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000,
  parameter int          ITER = 25
) (
  input  logic         clk,
  input  logic         rst,
  fp_div_seq_if.slave  bus
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM} state_t;
  typedef enum logic [1:0] {R_NORMAL, R_NAN, R_INF, R_ZERO} res_t;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [24:0]        r_rem;
  logic [23:0]        r_den;
  logic [24:0]        r_q;
  logic               r_sign;
  logic signed [9:0]  r_e;
  res_t               r_res;
  logic               r_dbz_pend;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_y;
  logic               r_dbz;

  fp_t  w_fa, w_fb;
  logic w_a_zero, w_a_inf, w_a_nan;
  logic w_b_zero, w_b_inf, w_b_nan;
  res_t w_res;
  logic w_dbz;

  assign w_fa = bus.a;
  assign w_fb = bus.b;

  // exp==0 covers denormals too: they are flushed to signed zero.
  assign w_a_zero = (w_fa.exp == 8'h00);
  assign w_a_inf  = (w_fa.exp == 8'hFF) && (w_fa.man == 23'd0);
  assign w_a_nan  = (w_fa.exp == 8'hFF) && (w_fa.man != 23'd0);
  assign w_b_zero = (w_fb.exp == 8'h00);
  assign w_b_inf  = (w_fb.exp == 8'hFF) && (w_fb.man == 23'd0);
  assign w_b_nan  = (w_fb.exp == 8'hFF) && (w_fb.man != 23'd0);

  always_comb begin
    w_res = R_NORMAL;
    w_dbz = 1'b0;
    if (w_a_nan || w_b_nan)                           w_res = R_NAN;
    else if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) w_res = R_NAN;
    else if (w_b_zero && !w_a_inf) begin
      w_res = R_INF;
      w_dbz = 1'b1;
    end
    else if (w_a_inf)                                 w_res = R_INF;
    else if (w_a_zero || w_b_inf)                     w_res = R_ZERO;
  end

  // Restoring step: remainder stays below den, so bit 24 is free for the shift.
  logic        w_ge;
  logic [24:0] w_rem_sub;
  assign w_ge      = (r_rem >= {1'b0, r_den});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_den}) : r_rem;

  logic signed [9:0] w_exp_n;
  logic [22:0]       w_man;
  logic [31:0]       w_y;

  assign w_exp_n = r_q[24] ? (r_e + 10'sd127) : (r_e + 10'sd126);
  assign w_man   = r_q[24] ? r_q[23:1] : r_q[22:0];

  always_comb begin
    w_y = {r_sign, 31'd0};
    case (r_res)
      R_NAN:  w_y = QNAN;
      R_INF:  w_y = {r_sign, 8'hFF, 23'd0};
      R_ZERO: w_y = {r_sign, 31'd0};
      default: begin
        if (w_exp_n >= 10'sd255)   w_y = {r_sign, 8'hFF, 23'd0};
        else if (w_exp_n <= 10'sd0) w_y = {r_sign, 31'd0};
        else                        w_y = {r_sign, w_exp_n[7:0], w_man};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_den      <= '0;
      r_q        <= '0;
      r_sign     <= 1'b0;
      r_e        <= '0;
      r_res      <= R_NORMAL;
      r_dbz_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_y        <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rem      <= {1'b0, 1'b1, w_fa.man};
            r_den      <= {1'b1, w_fb.man};
            r_q        <= '0;
            r_cnt      <= '0;
            r_sign     <= w_fa.sign ^ w_fb.sign;
            r_e        <= $signed({2'b00, w_fa.exp}) - $signed({2'b00, w_fb.exp});
            r_res      <= w_res;
            r_dbz_pend <= w_dbz;
            r_busy     <= 1'b1;
            r_state    <= S_DIV;
          end
        end
        S_DIV: begin
          r_q   <= {r_q[23:0], w_ge};
          r_rem <= {w_rem_sub[23:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(ITER - 1)) r_state <= S_NORM;
        end
        S_NORM: begin
          r_y     <= w_y;
          r_dbz   <= r_dbz_pend;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.y    = r_y;
  assign bus.dbz  = r_dbz;
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed vector table plus hand-written multi-cycle sequences for fp_div_seq.
module tb_fp_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0 = 0;

  fp_div_seq_if bus ();
  fp_div_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        dbz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] num;
    logic [47:0] q;
    int          e;
    logic [31:0] r;
    num = {1'b1, a[22:0], 24'd0};
    q   = num / {24'd0, 1'b1, b[22:0]};
    e   = int'(a[30:23]) - int'(b[30:23]);
    if (q[24]) r = {a[31] ^ b[31], 8'(e + 127), q[23:1]};
    else       r = {a[31] ^ b[31], 8'(e + 126), q[22:0]};
    return r;
  endfunction

  vec_t vecs[$];

  initial begin
    int lat, d1;
    logic saw;
    logic [31:0] ra, rb;

    vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0}); // 1/3
    vecs.push_back('{32'hBF800000, 32'h40000000, 32'hBF000000, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1});
    vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0});
    vecs.push_back('{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0}); // overflow
    vecs.push_back('{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0}); // underflow
    vecs.push_back('{32'h40000000, 32'hFF800000, 32'h80000000, 1'b0});
    vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0}); // 6/2
    vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0});
    vecs.push_back('{32'h40400000, 32'h40000000, 32'h3FC00000, 1'b0}); // 3/2
    vecs.push_back('{32'h3F800000, 32'hC0800000, 32'hBE800000, 1'b0}); // 1/-4
    vecs.push_back('{32'h40000000, 32'h40400000, 32'h3F2AAAAA, 1'b0}); // 2/3
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0}); // NaN in
    vecs.push_back('{32'h3F800000, 32'hFF800001, 32'h7FC00000, 1'b0}); // NaN divisor
    vecs.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0}); // inf/inf
    vecs.push_back('{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0});
    vecs.push_back('{32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0}); // inf/0: no dbz
    vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0}); // denormal flushed
    vecs.push_back('{32'hBF800000, 32'h00000001, 32'hFF800000, 1'b1}); // /denormal
    vecs.push_back('{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0});

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_y",    bus.y,             32'd0);
    chk("reset_dbz",  {31'd0, bus.dbz},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      chk($sformatf("busy_%0d", i), {31'd0, bus.busy}, 32'd1);
      wait_done(lat);
      chk($sformatf("lat_%0d", i), lat, 32'd26);
      chk($sformatf("y_%0d", i),   bus.y, vecs[i].y);
      chk($sformatf("dbz_%0d", i), {31'd0, bus.dbz}, {31'd0, vecs[i].dbz});
      @(posedge clk);
      #1;
      chk($sformatf("pulse_%0d", i), {31'd0, bus.done}, 32'd0);
      chk($sformatf("hold_y_%0d", i), bus.y, vecs[i].y);
    end

    // Abort mid-DIV with reset; no done may follow.
    start_op(32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_y", bus.y, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) saw = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw}, 32'd0);
    start_op(32'h40C00000, 32'h40000000);
    wait_done(lat);
    chk("restart_lat", lat, 32'd26);
    chk("restart_y", bus.y, 32'h40400000);
    chk("restart_dbz", {31'd0, bus.dbz}, 32'd0);

    // A second start while busy is ignored.
    start_op(32'h3F800000, 32'h40400000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'h40000000;
    bus.b = 32'h3F800000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat);
    chk("ignore_lat", lat, 32'd26);
    chk("ignore_y", bus.y, 32'h3EAAAAAA);
    @(posedge clk);
    #1;
    chk("ignore_no_second", {31'd0, bus.busy}, 32'd0);

    // Back-to-back: start raised in the done cycle.
    start_op(32'hBF800000, 32'h40000000);
    wait_done(lat);
    chk("b2b_lat1", lat, 32'd26);
    chk("b2b_y1", bus.y, 32'hBF000000);
    d1 = cyc;
    bus.start = 1'b1;
    bus.a = 32'h3F800000;
    bus.b = 32'h00000000;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.start = 1'b0;
    chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(lat);
    chk("b2b_gap", (lat < 0) ? -1 : (cyc - d1), 32'd27);
    chk("b2b_y2", bus.y, 32'h7F800000);
    chk("b2b_dbz2", {31'd0, bus.dbz}, 32'd1);

    // Random normal operands, exponents near 127.
    for (int i = 0; i < 10; i++) begin
      ra = {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
      start_op(ra, rb);
      wait_done(lat);
      chk($sformatf("rnd_lat_%0d", i), lat, 32'd26);
      chk($sformatf("rnd_y_%0d_%h_%h", i, ra, rb), bus.y, ref_div(ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Multi-cycle IEEE-754 single-precision divider; the inverse-direction companion to the fp_mult datapath in the lab4 arithmetic unit.
- Computes y = a / b with a start/done handshake.
- Uses a 1-bit-per-cycle restoring mantissa divider, so area stays small versus the combinational multiplier.
- Fixed latency for every operand class, so the bench and the surrounding control can schedule it blindly.

Parameters:
- QNAN, 32'h7FC0_0000, canonical quiet NaN emitted for every invalid or NaN result.
- ITER, 25, quotient bits produced (1 integer + 24 fraction); not intended to be changed.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  32  dividend, IEEE-754 single; sampled on the accepting edge
- b  in  32  divisor, IEEE-754 single; sampled on the accepting edge
- busy  out  1  high from the accepting edge until done is asserted
- done  out  1  one-cycle pulse; y is valid in that cycle
- y  out  32  quotient; held until the next accepted start
- dbz  out  1  divide-by-zero flag; valid with done, held with y

Behaviour:
- Reset: on a clk edge with rst=1, state=IDLE, busy=0, done=0, y=0, dbz=0, internal counter=0. Reset mid-operation aborts at once; no done is produced for the aborted operation.
- States:
  - IDLE -> DIV when start=1. That edge latches a and b, unpacks sign/exp/mantissa, classifies operands, loads rem=1.man_a (hidden bit set), den=1.man_b, cnt=0, busy=1.
  - DIV, per edge: if rem>=den, set q bit=1 and rem=rem-den; else q bit=0. Then rem<<=1 and cnt++. After ITER iterations, go to NORM.
  - NORM, one edge: select result, register y and dbz, done=1, busy=0, go to IDLE.
- Latency: start accepted at edge 0; done is high for exactly the cycle after edge 26. A new start is accepted in the cycle done is high (back-to-back).
- start in DIV or NORM is ignored; a and b may change freely while busy.
- Denormal inputs (exp=0) are flushed to signed zero before classification.
- Sign: sa XOR sb for all results except NaN.
- Normal path, with e = ea - eb computed on 10-bit signed:
  - q[24]=1: man = q[23:1], exp = e+127.
  - q[24]=0: man = q[22:0], exp = e+126.
  - Rounding is truncation (toward zero).
  - exp >= 255 -> signed infinity. exp <= 0 -> signed zero, no denormal output.
- Special cases, priority order; all take the same 26-cycle latency, with the DIV iterations run as don't-care:
  1. a or b NaN -> QNAN.
  2. inf/inf or 0/0 -> QNAN.
  3. finite nonzero / 0 -> signed inf, dbz=1.
  4. inf / finite -> signed inf.
  5. 0 / nonzero, or finite / inf -> signed zero.
- dbz is 0 for every other case, including 0/0.

Test Plan:
- Reset mid-DIV, 10 cycles after start(6.0/2.0): busy=0 next cycle, no done pulse follows, y=0. Restarting with a=0x40C00000, b=0x40000000 gives done at exactly cycle 26 with y=0x40400000, dbz=0.
- a=0x3F800000, b=0x40400000 (1/3) -> y=0x3EAAAAAA (truncated). a=0xBF800000, b=0x40000000 -> y=0xBF000000.
- a=0x3F800000, b=0x00000000 -> y=0x7F800000, dbz=1. a=0x00000000, b=0x00000000 -> y=0x7FC00000, dbz=0.
- Overflow a=0x7F000000, b=0x00800000 -> y=0x7F800000. Underflow a=0x00800000, b=0x7F000000 -> y=0x00000000. a=0x40000000, b=0xFF800000 -> y=0x80000000.
- Pulse start again 5 cycles into an operation with different operands: ignored; the original result appears at cycle 26.
- Back-to-back: assert start in the done cycle -> second done exactly 27 cycles after the first, both results correct. Random normal operands with exponents near 127: check against a reference model truncated toward zero.
